// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one 32-bit ALU (3-bit alucontrol) between two valid/ready requesters
// Ports: clk, reset (sync, active-high); reqN_valid/ready, reqN_a/b/op request channels;
// rspN_valid/ready response channels; rsp_data shared result; busy high in EXEC or RESP.
// Optional ALU_SHARE_ARBITER_STATS_EN adds saturating 16-bit grant_cnt0/grant_cnt1.
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
`ifdef ALU_SHARE_ARBITER_STATS_EN
    ,
    output logic [15:0]      grant_cnt0,
    output logic [15:0]      grant_cnt1
`endif
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state;
    logic owner, last_grant, sel;
    logic [WIDTH-1:0] a_q, b_q, bb, sum, alu_y;
    logic [OPW-1:0] op_q;
    // ALU_32: op[2] inverts b (and carries in 1), op[1:0] picks and/or/add/slt
    always_comb begin
        bb    = op_q[2] ? ~b_q : b_q;
        sum   = a_q + bb + {{(WIDTH-1){1'b0}}, op_q[2]};
        alu_y = op_q[1] ? (op_q[0] ? {{(WIDTH-1){1'b0}}, sum[WIDTH-1]} : sum)
                        : (op_q[0] ? (a_q | bb) : (a_q & bb));
    end
    // on a tie the requester that did not win last time is chosen
    always_comb begin
        sel        = (req0_valid && req1_valid) ? !last_grant : req1_valid;
        req0_ready = !reset && state == IDLE && req0_valid && !sel;
        req1_ready = !reset && state == IDLE && req1_valid && sel;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            rsp_data   <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req0_valid || req1_valid) begin
                    a_q   <= sel ? req1_a : req0_a;
                    b_q   <= sel ? req1_b : req0_b;
                    op_q  <= sel ? req1_op : req0_op;
                    owner <= sel;
                    busy  <= 1'b1;
                    state <= EXEC;
                end
                EXEC: begin
                    rsp_data   <= alu_y;
                    rsp0_valid <= !owner;
                    rsp1_valid <= owner;
                    state      <= RESP;
                end
                default: if (owner ? rsp1_ready : rsp0_ready) begin
                    rsp0_valid <= 1'b0;
                    rsp1_valid <= 1'b0;
                    last_grant <= owner;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end
`ifdef ALU_SHARE_ARBITER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (req0_valid && req0_ready && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
            if (req1_valid && req1_ready && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and randomized checks of alu_share_arbiter against an ALU reference model
module tb_alu_share_arbiter;
    logic clk = 0, reset = 1;
    logic req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
    logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [2:0] req0_op = 0, req1_op = 0;
    logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
    logic [31:0] rsp_data;
`ifdef ALU_SHARE_ARBITER_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1;
`endif
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    alu_share_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .busy(busy)
`ifdef ALU_SHARE_ARBITER_STATS_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
    );

    // reference ALU: and, or, add, sign of sum, and-not, or-not, sub, sign of difference
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        logic [31:0] s, d;
        s = a + b;
        d = a - b;
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return s;
            3'd3: return {31'b0, s[31]};
            3'd4: return a & ~b;
            3'd5: return a | ~b;
            3'd6: return d;
            default: return {31'b0, d[31]};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int n, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        if (n == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end
    endtask

    task automatic set_rr(input int n, input logic v);
        if (n == 0) rsp0_ready = v;
        else rsp1_ready = v;
    endtask

    function automatic logic rdy(input int n);
        return n == 0 ? req0_ready : req1_ready;
    endfunction

    function automatic logic rv(input int n);
        return n == 0 ? rsp0_valid : rsp1_valid;
    endfunction

    // one operation from requester n alone, optionally stalling the response for `stall` cycles
    task automatic run_op(input int n, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op, input int stall);
        logic [31:0] exp;
        exp = ref_alu(a, b, op);
        @(negedge clk);
        drive(n, 1'b1, a, b, op);
        rsp0_ready = 0;
        rsp1_ready = 0;
        #1;
        chk("ready_own", 32'(rdy(n)), 32'd1);
        chk("ready_other", 32'(rdy(1 - n)), 32'd0);
        @(negedge clk);
        drive(n, 1'b0, $urandom, $urandom, 3'($urandom_range(0, 7)));
        chk("exec_busy", 32'(busy), 32'd1);
        chk("exec_no_rsp", 32'(rv(n)), 32'd0);
        @(negedge clk);
        chk("rsp_valid", 32'(rv(n)), 32'd1);
        chk("rsp_other_valid", 32'(rv(1 - n)), 32'd0);
        chk("rsp_data", rsp_data, exp);
        if (stall > 0) begin
            set_rr(1 - n, 1'b1);
            req0_valid = 1;
            req1_valid = 1;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                chk("stall_valid", 32'(rv(n)), 32'd1);
                chk("stall_data", rsp_data, exp);
                chk("stall_ready0", 32'(req0_ready), 32'd0);
                chk("stall_ready1", 32'(req1_ready), 32'd0);
                chk("stall_busy", 32'(busy), 32'd1);
            end
            req0_valid = 0;
            req1_valid = 0;
            set_rr(1 - n, 1'b0);
        end
        set_rr(n, 1'b1);
        @(negedge clk);
        set_rr(n, 1'b0);
        chk("done_valid", 32'(rv(n)), 32'd0);
        chk("done_idle", 32'(busy), 32'd0);
        chk("done_hold", rsp_data, exp);
    endtask

    logic [31:0] ta [2][4];
    logic [31:0] tb [2][4];
    logic [2:0]  to [2][4];
    int idx [2];

    initial begin
        // reset state
        req0_valid = 1;
        repeat (2) @(negedge clk);
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_rsp0", 32'(rsp0_valid), 32'd0);
        chk("rst_rsp1", 32'(rsp1_valid), 32'd0);
        chk("rst_data", rsp_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        req0_valid = 0;
        reset = 0;

        run_op(0, 32'h5, 32'h3, 3'b010, 0);
        chk("add_direct", rsp_data, 32'h8);
        run_op(1, 32'hFF00FF00, 32'h0F0F0F0F, 3'b000, 0);
        chk("and_direct", rsp_data, 32'h0F000F00);
        run_op(1, 32'hFF00FF00, 32'h0F0F0F0F, 3'b001, 0);
        chk("or_direct", rsp_data, 32'hFF0FFF0F);
        run_op(0, $urandom, $urandom, 3'($urandom_range(0, 7)), 5);
        for (int i = 0; i < 8; i++)
            run_op(int'($urandom_range(0, 1)), $urandom, $urandom, 3'(i), 0);

        // both requesters valid from reset: grants must alternate starting at 0
        @(negedge clk);
        reset = 1;
        for (int n = 0; n < 2; n++)
            for (int k = 0; k < 4; k++) begin
                ta[n][k] = $urandom;
                tb[n][k] = $urandom;
                to[n][k] = 3'($urandom_range(0, 7));
            end
        idx[0] = 0;
        idx[1] = 0;
        drive(0, 1'b1, ta[0][0], tb[0][0], to[0][0]);
        drive(1, 1'b1, ta[1][0], tb[1][0], to[1][0]);
        rsp0_ready = 1;
        rsp1_ready = 1;
        repeat (2) @(negedge clk);
        chk("tie_rst_ready0", 32'(req0_ready), 32'd0);
        chk("tie_rst_ready1", 32'(req1_ready), 32'd0);
        reset = 0;
        for (int k = 0; k < 8; k++) begin
            int g, j;
            logic [31:0] exp;
            g = k % 2;
            j = idx[g];
            exp = ref_alu(ta[g][j], tb[g][j], to[g][j]);
            #1;
            chk("tie_grant", 32'(rdy(g)), 32'd1);
            chk("tie_nogrant", 32'(rdy(1 - g)), 32'd0);
            @(negedge clk);
            idx[g] = j + 1;
            if (j + 1 < 4) drive(g, 1'b1, ta[g][j + 1], tb[g][j + 1], to[g][j + 1]);
            else drive(g, 1'b0, 32'd0, 32'd0, 3'd0);
            chk("tie_busy", 32'(busy), 32'd1);
            @(negedge clk);
            chk("tie_rsp_valid", 32'(rv(g)), 32'd1);
            chk("tie_rsp_data", rsp_data, exp);
            @(negedge clk);
            chk("tie_rsp_done", 32'(rv(g)), 32'd0);
        end
`ifdef ALU_SHARE_ARBITER_STATS_EN
        chk("grant_cnt0", 32'(grant_cnt0), 32'd4);
        chk("grant_cnt1", 32'(grant_cnt1), 32'd4);
`endif
        rsp0_ready = 0;
        rsp1_ready = 0;

        // reset while requester 1's op is in EXEC
        @(negedge clk);
        drive(1, 1'b1, 32'h11111111, 32'h11111111, 3'b010);
        @(negedge clk);
        drive(1, 1'b0, 32'd0, 32'd0, 3'd0);
        chk("abort_in_exec", 32'(busy), 32'd1);
        reset = 1;
        rsp1_ready = 1;
        @(negedge clk);
        chk("abort_rsp1", 32'(rsp1_valid), 32'd0);
        chk("abort_rsp0", 32'(rsp0_valid), 32'd0);
        chk("abort_data", rsp_data, 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        reset = 0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_rsp1", 32'(rsp1_valid), 32'd0);
        end
        rsp1_ready = 0;
        run_op(0, 32'h12345678, 32'h00000008, 3'b010, 0);
        chk("post_abort", rsp_data, 32'h12345680);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
